// File: rtl/usr_lock_arbiter.sv
// Round-robin write-lock arbiter guarding one shared DATA_W-bit register among four users.
// Grant/ack/err/timeout appear one cycle after the request; requests made while owned are not queued.
module usr_lock_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          lock_req,
  input  logic [3:0]          unlock,
  input  logic [3:0]          wr_en,
  input  logic [4*DATA_W-1:0] wr_data,
  output logic [3:0]          lock_gnt,
  output logic [1:0]          owner_id,
  output logic                locked,
  output logic [DATA_W-1:0]   data_out,
  output logic                wr_ack,
  output logic                wr_err,
  output logic                timeout
);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_err_q, wr_err_d;
  logic                timeout_q, timeout_d;

  logic [1:0]          winner;
  logic                owner_wr;
  logic                owner_unl;
  logic [3:0]          owner_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd3;
      cnt_q     <= 8'd0;
      data_q    <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      timeout_q <= timeout_d;
    end
  end

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    winner = owner_q;
    for (int k = 4; k >= 1; k--) begin
      if (lock_req[2'(owner_q + 2'(k))]) winner = 2'(owner_q + 2'(k));
    end
  end

  assign owner_oh  = 4'b0001 << owner_q;
  assign owner_wr  = (state_q == OWNED) && wr_en[owner_q];
  assign owner_unl = (state_q == OWNED) && unlock[owner_q];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|lock_req) begin
          state_d = OWNED;
          owner_d = winner;
          cnt_d   = 8'd0;
        end
      end
      OWNED: begin
        cnt_d = owner_wr ? 8'd0 : cnt_q + 8'd1;
        if (owner_unl) begin
          state_d = IDLE;
        end else if (!owner_wr && cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    wr_ack_d = owner_wr;
    if (owner_wr) data_d = wr_data[owner_q*DATA_W +: DATA_W];
    if (state_q == OWNED) wr_err_d = |(wr_en & ~owner_oh);
    else                  wr_err_d = |wr_en;
  end

  always_comb begin
    lock_gnt = (state_q == OWNED) ? owner_oh : 4'b0000;
    locked   = (state_q == OWNED);
    owner_id = owner_q;
    data_out = data_q;
    wr_ack   = wr_ack_q;
    wr_err   = wr_err_q;
    timeout  = timeout_q;
  end

endmodule

// File: tb/tb_usr_lock_arbiter.sv
// Directed vector table plus hand-written timeout and async-reset sequences for usr_lock_arbiter.
module tb_usr_lock_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  lock_req, unlock, wr_en;
  logic [31:0] wr_data;
  logic [3:0]  lock_gnt;
  logic [1:0]  owner_id;
  logic        locked;
  logic [7:0]  data_out;
  logic        wr_ack, wr_err, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  usr_lock_arbiter #(.DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .lock_req(lock_req), .unlock(unlock), .wr_en(wr_en), .wr_data(wr_data),
    .lock_gnt(lock_gnt), .owner_id(owner_id), .locked(locked), .data_out(data_out),
    .wr_ack(wr_ack), .wr_err(wr_err), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req, unl, we;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic [1:0]  own;
    logic [7:0]  dat;
    logic        ack, err, to;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] unl,
                       input logic [3:0] we, input logic [31:0] wd);
    lock_req = req; unlock = unl; wr_en = we; wr_data = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] gnt, input logic [1:0] own,
                         input logic [7:0] dat, input logic ack, input logic err, input logic to);
    chk({tag, ".gnt"}, 32'(lock_gnt), 32'(gnt));
    chk({tag, ".owner"}, 32'(owner_id), 32'(own));
    chk({tag, ".locked"}, 32'(locked), 32'(|gnt));
    chk({tag, ".data"}, 32'(data_out), 32'(dat));
    chk({tag, ".ack"}, 32'(wr_ack), 32'(ack));
    chk({tag, ".err"}, 32'(wr_err), 32'(err));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  // Grant user u from IDLE; returns with the grant visible (cycle G).
  task automatic grant_user(input int u);
    drive(4'b0001 << u, 4'h0, 4'h0, 32'h0);
    step();
    drive(4'h0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    //          req      unl      we       wd             gnt      own   dat    ack   err   to
    vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0,        4'b0100, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0010, 32'h00003C00, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'b1111, 4'b0100, 4'b0000, 32'h0,        4'b0000, 2'd2, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0000, 32'h0,        4'b1000, 2'd3, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1000, 4'b0000, 32'h0,        4'b0000, 2'd3, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0000, 32'h0,        4'b0001, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0100, 4'b0000, 32'h0,        4'b0001, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 4'b0001, 4'b1001, 32'h7700005A, 4'b0000, 2'd0, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0001, 32'h000000C3, 4'b0000, 2'd0, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'b0000, 4'b1111, 4'b0000, 32'h0,        4'b0000, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 32'h0);
    #12;
    chk_all("reset", 4'b0000, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("post_reset_idle", 4'b0000, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].req, vecs[i].unl, vecs[i].we, vecs[i].wd);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].own, vecs[i].dat,
              vecs[i].ack, vecs[i].err, vecs[i].to);
    end
    drive(4'h0, 4'h0, 4'h0, 32'h0);

    // Idle timeout: grant at G, release with pulse at G+16.
    grant_user(1);
    chk("to1.grant", 32'(lock_gnt), 32'(4'b0010));
    for (int c = 1; c <= 15; c++) begin
      step();
      chk($sformatf("to1.held%0d", c), 32'({locked, timeout}), 32'(2'b10));
    end
    step();
    chk_all("to1.expire", 4'b0000, 2'd1, 8'h5A, 1'b0, 1'b0, 1'b1);
    step();
    chk("to1.pulse_end", 32'(timeout), 32'(0));

    // Owner write in the final cycle saves the lock and restarts the count.
    grant_user(1);
    for (int c = 1; c <= 15; c++) step();
    drive(4'h0, 4'h0, 4'b0010, 32'h00004400);
    step();
    drive(4'h0, 4'h0, 4'h0, 32'h0);
    chk_all("to2.saved", 4'b0010, 2'd1, 8'h44, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 15; c++) step();
    chk("to2.still_held", 32'({locked, timeout}), 32'(2'b10));
    step();
    chk_all("to2.expire", 4'b0000, 2'd1, 8'h44, 1'b0, 1'b0, 1'b1);

    // Owner unlock in the final cycle: normal release, no timeout pulse.
    step();
    grant_user(1);
    for (int c = 1; c <= 15; c++) step();
    drive(4'h0, 4'b0010, 4'h0, 32'h0);
    step();
    drive(4'h0, 4'h0, 4'h0, 32'h0);
    chk_all("to3.unlock_last", 4'b0000, 2'd1, 8'h44, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-ownership clears everything without a clock edge.
    step();
    grant_user(2);
    drive(4'h0, 4'h0, 4'b0100, 32'h00FF0000);
    step();
    drive(4'h0, 4'h0, 4'h0, 32'h0);
    chk("arst.pre_data", 32'(data_out), 32'(8'hFF));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("arst.async", 4'b0000, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    #10;
    rst_n = 1'b1;
    step();
    drive(4'b1111, 4'h0, 4'h0, 32'h0);
    step();
    chk("arst.rr_first_user0", 32'(lock_gnt), 32'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usr_lock_arbiter.md
Name: usr_lock_arbiter

Overview:
- Arbitrates exclusive write ownership of one shared 8-bit user-locked data register among four user IDs (0..3).
- A user acquires the lock by request; only the current owner's writes update the register, and all other writes are rejected and flagged.
- The lock is released by the owner or by an inactivity timeout.
- Sits between the per-user bus agents and the protected configuration register.

Parameters:
- DATA_W, 8, width of stored data and of each per-user write data lane.
- TIMEOUT, 16, owned cycles without an owner write before forced release; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lock_req  input  4  per-user level request for the lock; bit i = user i.
- unlock  input  4  per-user release request; honoured only from the current owner.
- wr_en  input  4  per-user write strobe.
- wr_data  input  4*DATA_W  packed write data; lane i is bits [i*DATA_W +: DATA_W].
- lock_gnt  output  4  one-hot registered grant; all zero when unlocked.
- owner_id  output  2  current owner index; holds last owner while unlocked.
- locked  output  1  high while a user owns the lock.
- data_out  output  DATA_W  protected register contents.
- wr_ack  output  1  one-cycle pulse: owner write committed.
- wr_err  output  1  one-cycle pulse: at least one rejected write.
- timeout  output  1  one-cycle pulse: lock force-released by inactivity.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - data_out = 0, lock_gnt = 0, locked = 0, owner_id = 3.
  - wr_ack, wr_err and timeout = 0; idle counter = 0; FSM in IDLE.
  - Round-robin pointer = 3, so user 0 has first priority after reset.
- Reset asserted mid-operation clears everything immediately, including the stored data.
- FSM states: IDLE, OWNED.
- IDLE:
  - If any lock_req bit is set in cycle N, the winner is chosen round-robin, searching from owner_id+1 upward with wrap 3->0.
  - In cycle N+1: lock_gnt is the winner's one-hot, owner_id = winner, locked = 1, state = OWNED, counter = 0.
  - wr_en in IDLE: no update; wr_err pulses in N+1.
  - unlock in IDLE: ignored.
- OWNED:
  - Owner write (wr_en[owner_id] in cycle N): data_out = owner lane in N+1; wr_ack = 1 in N+1; counter cleared.
  - Non-owner write in any cycle: no data change; wr_err = 1 in N+1.
  - Owner write together with any non-owner write in the same cycle: the owner write commits; wr_ack and wr_err both pulse.
  - unlock[owner_id] in cycle N: in N+1 state = IDLE, locked = 0, lock_gnt = 0, owner_id retained as the RR pointer.
  - unlock from a non-owner: ignored, no error.
  - Owner write plus owner unlock in the same cycle: the write commits (wr_ack pulses) and the release happens in N+1.
  - lock_req from other users while OWNED: ignored; no queueing, requesters hold their level.
  - Counter increments each OWNED cycle without an owner write.
  - Timeout: when counter == TIMEOUT-1 and the cycle has neither an owner write nor an owner unlock, the next cycle is IDLE with timeout = 1 for one cycle.
  - Result: a grant first visible at cycle G with no activity releases at cycle G+TIMEOUT.
  - An owner write in the final cycle saves the lock.
  - An owner unlock in the final cycle releases normally, without a timeout pulse.
- Re-arbitration: a release at cycle N+1 allows a new grant at the earliest in N+2, since the FSM spends at least one cycle in IDLE.
- Width rules: counter is 8 bits and saturation is not needed; owner_id is 2 bits and wraps mod 4.
- Invariants:
  - lock_gnt is one-hot or zero.
  - locked equals the OR of lock_gnt.
  - data_out never changes except on wr_ack or reset.

Test Plan:
- Reset then lock_req=4'b0100, wr_en[2]=1 with lane 2 = 8'hA5 -> lock_gnt=4'b0100 one cycle after the request; data_out=8'hA5 and wr_ack=1 one cycle after the write.
- User 2 owns; wr_en[1]=1 with lane 1 = 8'h3C -> data_out stays 8'hA5, wr_err=1 for one cycle, wr_ack=0.
- User 2 owns; lock_req=4'b1111 held, user 2 asserts unlock -> locked=0 for one cycle, then lock_gnt=4'b1000 (user 3). After user 3 releases, the next grant goes to user 0.
- TIMEOUT=16; grant user 1 at cycle G, no writes -> timeout=1 and locked=0 at G+16. Repeat with an owner write at G+15 -> lock held, and the counter restarts.
- Owner 0 asserts wr_en[0] (8'h5A), unlock[0] and wr_en[3] in the same cycle -> next cycle: data_out=8'h5A, wr_ack=1, wr_err=1, locked=0.
- rst_n dropped mid-ownership with data_out=8'hFF -> data_out=0, lock_gnt=0 and owner_id=3 immediately, without waiting for a clock edge.
